mem_arbiter: RTL

- Round-robin arbiter sharing the single system memory write/read port between N requesters: sample renderer, grid/text overlay, display refresh reader and others.
- Each requester uses the standard arbiter handshake:
  - Requester holds req, addr, data and wr stable until it sees a one-cycle ack.
  - Requester drops req on the edge that samples ack.
- The arbiter registers the winning request, forwards it to the memory controller, and returns ack when the controller completes.

---
 rtl/mem_arbiter.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter that shares one system memory port among
//            N requesters using a req/ack handshake. The winning request is
//            registered and forwarded to the memory controller. The
//            requester's ack is returned when the controller completes.
// Options  : ARB_PRIO0_EN - requester 0 has fixed top priority. The other
//            requesters rotate among themselves.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int N  = 4,
  parameter int AW = 24,
  parameter int DW = 16
) (
  input  logic                   clkSYS,
  input  logic                   reset,
  input  logic [N-1:0]           req,
  input  logic [N*AW-1:0]        addr,
  input  logic [N*DW-1:0]        data,
  input  logic [N-1:0]           wr,
  output logic [N-1:0]           ack,
  output logic [DW-1:0]          rdata,
  output logic                   mem_req,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_data,
  output logic                   mem_wr,
  input  logic                   mem_ack,
  input  logic [DW-1:0]          mem_rdata,
  output logic                   busy,
  output logic [$clog2(N)-1:0]   grant
);

  localparam int              c_GW   = $clog2(N);
  localparam logic [c_GW-1:0] c_LAST = c_GW'(N - 1);

  typedef enum logic [1:0] {
    c_IDLE = 2'd0,
    c_BUS  = 2'd1,
    c_GAP  = 2'd2
  } state_t;

  state_t            r_state;
  logic [c_GW-1:0]   r_grant;
  logic [N-1:0]      r_ack;
  logic [DW-1:0]     r_rdata;
  logic              r_mem_req;
  logic [AW-1:0]     r_mem_addr;
  logic [DW-1:0]     r_mem_data;
  logic              r_mem_wr;
  logic              r_busy;

  state_t            w_state_nxt;
  logic [c_GW-1:0]   w_grant_nxt;
  logic [N-1:0]      w_ack_nxt;
  logic [DW-1:0]     w_rdata_nxt;
  logic              w_mem_req_nxt;
  logic [AW-1:0]     w_mem_addr_nxt;
  logic [DW-1:0]     w_mem_data_nxt;
  logic              w_mem_wr_nxt;

  logic              w_found;
  logic [c_GW-1:0]   w_winner;
  logic [c_GW-1:0]   w_idx;
  logic [AW-1:0]     w_sel_addr;
  logic [DW-1:0]     w_sel_data;
  logic              w_sel_wr;

`ifdef ARB_PRIO0_EN
  // Rotation pointer for requesters 1..N-1. Requester 0 grants never move it.
  logic [c_GW-1:0]   r_rr_ptr;
  logic [c_GW-1:0]   w_rr_ptr_nxt;

  // Winner search: requester 0 first, then rotate among 1..N-1 after the pointer
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    if (req[0]) begin
      w_found  = 1'b1;
      w_winner = '0;
    end else begin
      for (int k = 1; k < N; k++) begin
        w_idx = c_GW'(1 + ((int'(r_rr_ptr) - 1 + k) % (N - 1)));
        if (!w_found && req[w_idx]) begin
          w_found  = 1'b1;
          w_winner = w_idx;
        end
      end
    end
  end
`else
  // Winner search: the first set request after the last grant, wrapping modulo N
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = c_GW'((int'(r_grant) + k) % N);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end
`endif

  // Pick the winner's address/data/direction slices out of the packed buses
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_wr   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_winner == c_GW'(i)) begin
        w_sel_addr = addr[i*AW +: AW];
        w_sel_data = data[i*DW +: DW];
        w_sel_wr   = wr[i];
      end
    end
  end

  // Next-state and next-output logic. Everything holds unless a state acts on it.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_ack_nxt      = '0;
    w_rdata_nxt    = r_rdata;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_mem_data_nxt = r_mem_data;
    w_mem_wr_nxt   = r_mem_wr;
`ifdef ARB_PRIO0_EN
    w_rr_ptr_nxt   = r_rr_ptr;
`endif
    case (r_state)
      c_IDLE: begin
        if (w_found) begin
          w_state_nxt    = c_BUS;
          w_grant_nxt    = w_winner;
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = w_sel_addr;
          w_mem_data_nxt = w_sel_data;
          w_mem_wr_nxt   = w_sel_wr;
`ifdef ARB_PRIO0_EN
          if (w_winner != '0) begin
            w_rr_ptr_nxt = w_winner;
          end
`endif
        end
      end
      c_BUS: begin
        // Grant is locked until the controller completes; req changes are ignored
        if (mem_ack) begin
          w_state_nxt        = c_GAP;
          w_mem_req_nxt      = 1'b0;
          w_ack_nxt[r_grant] = 1'b1;
          w_rdata_nxt        = mem_rdata;
        end
      end
      c_GAP: begin
        // Dead cycle so the acknowledged requester's registered req can drop
        w_state_nxt = c_IDLE;
      end
      default: begin
        w_state_nxt   = c_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; busy is decoded from the next state
  always_ff @(posedge clkSYS or posedge reset) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_grant    <= c_LAST;
      r_ack      <= '0;
      r_rdata    <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_wr   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_ack      <= w_ack_nxt;
      r_rdata    <= w_rdata_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_mem_data <= w_mem_data_nxt;
      r_mem_wr   <= w_mem_wr_nxt;
      r_busy     <= (w_state_nxt != c_IDLE);
    end
  end

`ifdef ARB_PRIO0_EN
  // Rotation pointer register; the reset value makes requester 1 the first searched
  always_ff @(posedge clkSYS or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= c_LAST;
    end else begin
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end
`endif

  assign ack      = r_ack;
  assign rdata    = r_rdata;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign mem_wr   = r_mem_wr;
  assign busy     = r_busy;
  assign grant    = r_grant;

endmodule
`default_nettype wire
